// File: rtl/rv_defs_pkg.sv
// Shared miniRV definitions: writeback source selects, load funct3 codes and
// the MEM/WB handshake states.
package rv_defs_pkg;

  localparam int unsigned RF_WSEL_PC   = 0;
  localparam int unsigned RF_WSEL_EXT  = 1;
  localparam int unsigned RF_WSEL_ALU  = 2;
  localparam int unsigned RF_WSEL_DRAM = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load-return alignment: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it; flags halfword/word accesses that are misaligned.
module load_align
  import rv_defs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  // NOTE: every output of a combinational block gets a default first, otherwise
  // an uncovered funct3 code would infer a latch.
  always_comb begin
    data_o     = shifted;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LH: begin
        data_o     = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        misalign_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o     = {{(XLEN-16){1'b0}}, shifted[15:0]};
        misalign_o = addr_lo_i[0];
      end
      F3_LW: begin
        data_o     = rdata_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// miniRV MEM/WB stage: registered writeback mux plus variable-latency load return.
// Optional byte/half load alignment is enabled by defining WB_LOAD_ALIGN_EN.
module mem_wb_stage
  import rv_defs_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  wD_i,
  input  logic [SEL_W-1:0] rf_wsel_i,
  input  logic             rf_we_i,
  input  logic [4:0]       wR_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [XLEN-1:0]  dram_rdata_i,
  input  logic             dram_rvalid_i,
  output logic             stall_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_wR_o,
  output logic [XLEN-1:0]  rf_wD_o,
  output logic             err_o
);

  localparam int unsigned CNT_W = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [4:0]       wr_q, wr_d;
  logic [XLEN-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic             ld_we_q, ld_we_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic [2:0]       ld_f3_q, ld_f3_d;
  logic [1:0]       ld_lo_q, ld_lo_d;

  logic             is_load;
  logic             sel_known;
  logic [XLEN-1:0]  load_data;
  logic             load_misalign;

  assign is_load   = (rf_wsel_i == SEL_W'(RF_WSEL_DRAM));
  assign sel_known = (rf_wsel_i == SEL_W'(RF_WSEL_PC))  ||
                     (rf_wsel_i == SEL_W'(RF_WSEL_EXT)) ||
                     (rf_wsel_i == SEL_W'(RF_WSEL_ALU));

`ifdef WB_LOAD_ALIGN_EN
  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i    (dram_rdata_i),
    .funct3_i   (ld_f3_q),
    .addr_lo_i  (ld_lo_q),
    .data_o     (load_data),
    .misalign_o (load_misalign)
  );
`else
  // Without alignment the raw word is written; the latched size fields are dead.
  logic unused_align;
  assign unused_align  = ^{ld_f3_q, ld_lo_q};
  assign load_data     = dram_rdata_i;
  assign load_misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wr_d    = wr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    ld_we_d = ld_we_q;
    ld_rd_d = ld_rd_q;
    ld_f3_d = ld_f3_q;
    ld_lo_d = ld_lo_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_load) begin
            ld_we_d = rf_we_i;
            ld_rd_d = wR_i;
            ld_f3_d = funct3_i;
            ld_lo_d = addr_lo_i;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            we_d = rf_we_i && (wR_i != 5'd0);
            wr_d = wR_i;
            wd_d = sel_known ? wD_i : '0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Returned data wins over a timeout landing in the same cycle.
        if (dram_rvalid_i) begin
          state_d = IDLE;
          if (load_misalign) begin
            err_d = 1'b1;
          end else begin
            we_d = ld_we_q && (ld_rd_q != 5'd0);
            wr_d = ld_rd_q;
            wd_d = load_data;
          end
        end else if ((LOAD_TIMEOUT != 0) && (cnt_d == CNT_W'(LOAD_TIMEOUT))) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      ld_we_q <= 1'b0;
      ld_rd_q <= '0;
      ld_f3_q <= '0;
      ld_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      ld_we_q <= ld_we_d;
      ld_rd_q <= ld_rd_d;
      ld_f3_q <= ld_f3_d;
      ld_lo_q <= ld_lo_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign stall_o = ~ready_o;
  assign rf_we_o = we_q;
  assign rf_wR_o = wr_q;
  assign rf_wD_o = wd_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected RF writes, a
// negedge monitor pops and compares each rf_we_o pulse.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] wD_i;
  logic [1:0]  rf_wsel_i;
  logic        rf_we_i;
  logic [4:0]  wR_i;
  logic [2:0]  funct3_i;
  logic [1:0]  addr_lo_i;
  logic [31:0] dram_rdata_i;
  logic        dram_rvalid_i;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_wR_o;
  logic [31:0] rf_wD_o;
  logic        err_o;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  mem_wb_stage #(.XLEN(32), .SEL_W(2), .LOAD_TIMEOUT(15)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .wD_i          (wD_i),
    .rf_wsel_i     (rf_wsel_i),
    .rf_we_i       (rf_we_i),
    .wR_i          (wR_i),
    .funct3_i      (funct3_i),
    .addr_lo_i     (addr_lo_i),
    .dram_rdata_i  (dram_rdata_i),
    .dram_rvalid_i (dram_rvalid_i),
    .stall_o       (stall_o),
    .rf_we_o       (rf_we_o),
    .rf_wR_o       (rf_wR_o),
    .rf_wD_o       (rf_wD_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && rf_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got wR=%0d wD=0x%08h, expected no write", rf_wR_o, rf_wD_o);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("wb_wR", {27'd0, rf_wR_o}, {27'd0, e.wr});
        check("wb_wD", rf_wD_o, e.wd);
      end
    end
  end

  // Non-load op: one cycle on the bus; the next call may follow back-to-back.
  task automatic issue_op(input logic [1:0] sel, input logic [31:0] wd, input logic [4:0] wr,
                          input logic we, input logic exp_wr);
    valid_i   = 1'b1;
    rf_wsel_i = sel;
    wD_i      = wd;
    wR_i      = wr;
    rf_we_i   = we;
    check("op_ready", {31'd0, ready_o}, 32'd1);
    if (exp_wr) exp_q.push_back('{wr: wr, wd: wd});
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  // Load whose data returns in WAIT cycle n; exp_wr says whether a write should follow.
  task automatic issue_load(input string name, input logic [4:0] wr, input logic [2:0] f3,
                            input logic [1:0] lo, input int n, input logic [31:0] rdata,
                            input logic exp_wr, input logic [31:0] exp_wd);
    int stalls;
    valid_i   = 1'b1;
    rf_wsel_i = 2'd3;
    wD_i      = 32'h5555_5555;
    wR_i      = wr;
    rf_we_i   = 1'b1;
    funct3_i  = f3;
    addr_lo_i = lo;
    @(posedge clk_i); #1;
    valid_i  = 1'b0;
    wR_i     = 5'd0;
    funct3_i = 3'b111;
    stalls   = 0;
    for (int k = 1; k <= n; k++) begin
      if (stall_o) stalls++;
      if (k == n) begin
        dram_rvalid_i = 1'b1;
        dram_rdata_i  = rdata;
        if (exp_wr) exp_q.push_back('{wr: wr, wd: exp_wd});
      end
      @(posedge clk_i); #1;
    end
    dram_rvalid_i = 1'b0;
    dram_rdata_i  = 32'h0;
    check({name, "_stall_cycles"}, stalls, n);
    check({name, "_ready_after"}, {31'd0, ready_o}, 32'd1);
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    valid_i = 1'b0; wD_i = '0; rf_wsel_i = '0; rf_we_i = 1'b0; wR_i = '0;
    funct3_i = 3'b010; addr_lo_i = '0; dram_rdata_i = '0; dram_rvalid_i = 1'b0;
    apply_reset();

    // Reset state
    check("rst_we", {31'd0, rf_we_o}, 32'd0);
    check("rst_wR", {27'd0, rf_wR_o}, 32'd0);
    check("rst_wD", rf_wD_o, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_stall", {31'd0, stall_o}, 32'd0);

    // ALU op, then back-to-back PC / EXT / ALU ops at one per cycle
    issue_op(2'd2, 32'h0000_1234, 5'd5, 1'b1, 1'b1);
    issue_op(2'd0, 32'h0000_0104, 5'd1, 1'b1, 1'b1);
    issue_op(2'd1, 32'hFFFF_F800, 5'd31, 1'b1, 1'b1);
    issue_op(2'd2, 32'hA5A5_0F0F, 5'd12, 1'b1, 1'b1);
    // rf_we_i low, and rd = x0 with rf_we_i high: no write
    issue_op(2'd2, 32'h0BAD_0001, 5'd9, 1'b0, 1'b0);
    issue_op(2'd2, 32'h0BAD_0002, 5'd0, 1'b1, 1'b0);
    @(negedge clk_i);
    check("x0_no_we", {31'd0, rf_we_o}, 32'd0);
    @(posedge clk_i); #1;

    // LW, data on the third WAIT cycle
    issue_load("lw", 5'd7, 3'b010, 2'd0, 3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    issue_load("lw_fast", 5'd20, 3'b010, 2'd0, 1, 32'h0000_0042, 1'b1, 32'h0000_0042);
    issue_op(2'd2, 32'h0000_5678, 5'd3, 1'b1, 1'b1);
    @(negedge clk_i);
    check("err_clear_before_timeout", {31'd0, err_o}, 32'd0);
    @(posedge clk_i); #1;

`ifdef WB_LOAD_ALIGN_EN
    issue_load("lb", 5'd8, 3'b000, 2'd3, 2, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80);
    issue_load("lbu", 5'd9, 3'b100, 2'd3, 2, 32'h80FF_0000, 1'b1, 32'h0000_0080);
    issue_load("lh", 5'd10, 3'b001, 2'd2, 2, 32'h80FF_0000, 1'b1, 32'hFFFF_80FF);
    issue_load("lhu", 5'd11, 3'b101, 2'd0, 1, 32'h1234_8001, 1'b1, 32'h0000_8001);
    issue_load("lw_misalign", 5'd12, 3'b010, 2'd1, 2, 32'h1111_2222, 1'b0, 32'h0);
    check("misalign_err", {31'd0, err_o}, 32'd1);
    apply_reset();
`else
    // Size fields are ignored without alignment: raw word returned
    issue_load("lb_raw", 5'd8, 3'b000, 2'd3, 2, 32'h80FF_0000, 1'b1, 32'h80FF_0000);
`endif

    // Timeout: no rvalid, abandoned after 15 WAIT cycles
    valid_i = 1'b1; rf_wsel_i = 2'd3; wR_i = 5'd14; rf_we_i = 1'b1; funct3_i = 3'b010; addr_lo_i = 2'd0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    stalls = 0;
    while (stall_o && stalls < 40) begin
      stalls++;
      @(posedge clk_i); #1;
    end
    check("timeout_cycles", stalls, 15);
    check("timeout_err", {31'd0, err_o}, 32'd1);
    check("timeout_no_we", {31'd0, rf_we_o}, 32'd0);
    // Late rvalid while idle is ignored
    dram_rvalid_i = 1'b1; dram_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    dram_rvalid_i = 1'b0;
    check("late_rvalid_idle", {31'd0, rf_we_o}, 32'd0);
    issue_op(2'd2, 32'h0000_0777, 5'd6, 1'b1, 1'b1);
    repeat (3) @(posedge clk_i); #1;
    check("err_sticky", {31'd0, err_o}, 32'd1);

    // Reset while a load is in flight, then a late rvalid
    valid_i = 1'b1; rf_wsel_i = 2'd3; wR_i = 5'd15; rf_we_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("wait_stall", {31'd0, stall_o}, 32'd1);
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    check("rst_in_wait_ready", {31'd0, ready_o}, 32'd1);
    check("rst_clears_err", {31'd0, err_o}, 32'd0);
    check("rst_clears_wD", rf_wD_o, 32'd0);
    dram_rvalid_i = 1'b1; dram_rdata_i = 32'h1357_9BDF;
    @(posedge clk_i); #1;
    dram_rvalid_i = 1'b0;
    check("rst_drop_no_we", {31'd0, rf_we_o}, 32'd0);
    check("rst_drop_idle", {31'd0, ready_o}, 32'd1);

    issue_op(2'd1, 32'h0000_00AB, 5'd2, 1'b1, 1'b1);
    repeat (2) @(posedge clk_i); #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
